// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - 2-entry IF/ID pipeline FIFO with flush; optional bubble counter via IFID_BUBBLE_CNT_EN
module if_id_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] Instruction_if,
    input  logic [31:0] PC_if,
    input  logic        IF_flush,
    output logic        IFWrite,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id
`ifdef IFID_BUBBLE_CNT_EN
    ,
    output logic [15:0] bubble_cnt
`endif
);

    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0] pc_0, pc_1, ins_0, ins_1;
    logic        head, tail;
    logic [1:0]  count;
    logic        push, pop;

    // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    assign IFWrite  = (count != 2'd2);
    assign id_valid = (count != 2'd0);
    assign push     = in_valid & IFWrite & ~IF_flush;
    assign pop      = id_valid & id_ready;

    assign Instruction_id = id_valid ? (head ? ins_1 : ins_0) : NOP;
    assign PC_id          = id_valid ? (head ? pc_1 : pc_0) : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_0  <= 32'h0;
            pc_1  <= 32'h0;
            ins_0 <= 32'h0;
            ins_1 <= 32'h0;
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else if (IF_flush) begin
            // The head may be popped this cycle, but everything younger is wrong-path.
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                if (tail) begin
                    pc_1  <= PC_if;
                    ins_1 <= Instruction_if;
                end else begin
                    pc_0  <= PC_if;
                    ins_0 <= Instruction_if;
                end
                tail <= ~tail;
            end
            if (pop)
                head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef IFID_BUBBLE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bubble_cnt <= 16'h0;
        else if (!id_valid && bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'h1;
    end
`endif

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 The block SHALL have a single clock, and its reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous active-low reset; 0 = reset.
REQ-004 in_valid  input  1  fetch stage presents a packet this cycle.
REQ-005 Instruction_if  input  32  fetched instruction word.
REQ-006 PC_if  input  32  address of Instruction_if.
REQ-007 IF_flush  input  1  taken branch/jump; wrong-path instructions are discarded.
REQ-008 IFWrite  output  1  ready to fetch; 1 = packet accepted this cycle; drives the fetch-stage PC enable.
REQ-009 id_ready  input  1  decode stage consumes the head packet this cycle.
REQ-010 id_valid  output  1  head packet valid.
REQ-011 Instruction_id  output  32  head instruction word.
REQ-012 PC_id  output  32  head instruction address.
REQ-013 bubble_cnt  output  16  decode-idle cycle count; the port exists only when IFID_BUBBLE_CNT_EN is defined.

Function
REQ-014 Storage SHALL be a 2-entry FIFO of {PC, instruction} packets, with head/tail pointers and a 2-bit occupancy count (0..2).
REQ-015 IFWrite SHALL equal (count != 2), driven combinationally from registered count only, with no input bypass.
REQ-016 A push SHALL occur when in_valid & IFWrite & ~IF_flush.
REQ-017 A pop SHALL occur when id_valid & id_ready.
REQ-018 id_valid SHALL equal (count != 0).
REQ-019 Instruction_id and PC_id SHALL be the head entry when id_valid=1; when id_valid=0 they SHALL be 32'h00000013 (NOP) and 32'h0.
REQ-020 Latency: a packet pushed into an empty buffer at edge N SHALL be visible on the outputs after edge N; there SHALL be no same-cycle input-to-output path.
REQ-021 Throughput: one push plus one pop per cycle SHALL be sustained at count=1; count then stays at 1.
REQ-022 At count=2, a pop SHALL free a slot for the next cycle only; the same cycle's in_valid is not accepted.
REQ-023 On a pop at count=0, no state SHALL change (id_valid=0 makes this unreachable).
REQ-024 Pointers SHALL wrap modulo 2.
REQ-025 On IF_flush=1 at an edge, count SHALL be set to 0 and both pointers to 0, and the incoming packet SHALL be dropped.
REQ-026 A pop in the same cycle as IF_flush SHALL be honoured: the branch instruction is consumed and all younger entries are discarded.
REQ-027 After a flush, id_valid=0 for at least one cycle.
REQ-028 IF_flush SHALL take priority over push; pop SHALL be irrelevant to the resulting count, which is 0.
REQ-029 Entry data registers SHALL be written only on push; stale entry contents are never observable.

Reset
REQ-030 While reset=0, state SHALL be forced to count=0, pointers=0, entry storage=0, and bubble_cnt=0.
REQ-031 While reset=0 the outputs SHALL be id_valid=0, Instruction_id=32'h00000013, PC_id=0, and IFWrite=1.
REQ-032 Reset asserted mid-operation SHALL discard all buffered packets immediately, without waiting for a clock edge.
REQ-033 The first push SHALL be accepted at the first rising edge with reset=1.

Configuration
REQ-034 The macro IFID_BUBBLE_CNT_EN SHALL control the bubble counter.
REQ-035 When IFID_BUBBLE_CNT_EN is defined, bubble_cnt SHALL increment by 1 on each edge with id_valid=0, saturate at 16'hFFFF, and be unaffected by IF_flush.
REQ-036 When IFID_BUBBLE_CNT_EN is undefined, the bubble_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Reset then idle: reset=0 for 3 cycles, then release -> id_valid=0, Instruction_id=0x00000013, PC_id=0, IFWrite=1; bubble_cnt (if enabled) counts 1,2,3 after release.
REQ-038 Streaming: in_valid=1 with PCs 0x0,0x4,0x8 and id_ready=1 -> id_valid=1 from the cycle after the first push; PC_id sequence 0x0,0x4,0x8, one per cycle; count stays at 1.
REQ-039 Full/stall: id_ready=0, push 0x10 and 0x14 -> IFWrite=0 at count=2; a third packet 0x18 is not accepted; raise id_ready -> PC_id 0x10, then 0x14; 0x18 is accepted one cycle after the first pop.
REQ-040 Flush with pop: buffer holds 0x20,0x24; assert id_ready=1, IF_flush=1, and in_valid with 0x28 -> 0x20 consumed; next cycle id_valid=0, 0x24 and 0x28 never appear; the next push of JumpAddr 0x100 appears as PC_id=0x100.
REQ-041 Async reset mid-run: count=2, reset driven to 0 between edges -> id_valid=0 and IFWrite=1 immediately, before the next edge.
REQ-042 Saturation (IFID_BUBBLE_CNT_EN defined): idle 65540 cycles -> bubble_cnt holds 0xFFFF.
